// File: rtl/fsm_stim_sequencer.sv
// Runs one stimulus pass over a small serial-input Moore FSM. It shifts a latched pattern into x,
// LSB first, and records F after each bit along with the count of F=1 samples.
module fsm_stim_sequencer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CW-1:0]    len,
  input  logic             dut_f,
  output logic             dut_x,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] f_trace,
  output logic [CW-1:0]    f_count
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [CW-1:0] LenMax = CW'(WIDTH);

  typedef enum logic [2:0] {StIdle, StDrst, StShift, StSettle, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] f_trace_q, f_trace_d;
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    f_count_q, f_count_d;
  logic             aborted_q, aborted_d;
  logic [CW-1:0]    len_eff;
  logic [CW-1:0]    last_idx;
  logic             in_run;

  assign len_eff  = (len == '0 || len > LenMax) ? LenMax : len;
  assign last_idx = len_q - CW'(1);
  assign in_run   = (state_q == StDrst) || (state_q == StShift) || (state_q == StSettle);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    f_trace_d = f_trace_q;
    f_count_d = f_count_q;
    aborted_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d     = pattern;
          len_d     = len_eff;
          idx_d     = '0;
          f_trace_d = '0;
          f_count_d = '0;
          state_d   = StDrst;
        end
      end
      StDrst: begin
        idx_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        // F reflects the bit shifted in on the previous cycle.
        if (idx_q != '0) begin
          f_trace_d[IW'(idx_q - CW'(1))] = dut_f;
          f_count_d = f_count_q + CW'(dut_f);
        end
        if (idx_q == last_idx) begin
          state_d = StSettle;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      StSettle: begin
        f_trace_d[last_idx[IW-1:0]] = dut_f;
        f_count_d = f_count_q + CW'(dut_f);
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides any progress, but captures made this cycle are kept.
    if (abort && in_run) begin
      state_d   = StIdle;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      f_trace_q <= '0;
      f_count_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      f_trace_q <= f_trace_d;
      f_count_q <= f_count_d;
      aborted_q <= aborted_d;
    end
  end

  assign dut_x   = (state_q == StShift) & pat_q[idx_q[IW-1:0]];
  assign dut_rst = rst | (state_q == StDrst);
  assign busy    = in_run;
  assign done    = (state_q == StDone);
  assign aborted = aborted_q;
  assign f_trace = f_trace_q;
  assign f_count = f_count_q;

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Bench for fsm_stim_sequencer: a delayed-x stub stands in for the controlled FSM, and a queue
// scoreboard checks every done/aborted pulse against a pattern-mask reference model.
module tb_fsm_stim_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic       dut_f;
  logic       dut_x;
  logic       dut_rst;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] f_trace;
  logic [3:0] f_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic        is_abort;
    logic [31:0] cyc;
    logic [7:0]  trace;
    logic [3:0]  count;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  fsm_stim_sequencer #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .dut_f   (dut_f),
    .dut_x   (dut_x),
    .dut_rst (dut_rst),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .f_trace (f_trace),
    .f_count (f_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the controlled FSM: F is x delayed one cycle, cleared by its reset.
  always @(posedge clk) dut_f <= dut_rst ? 1'b0 : dut_x;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // With the stub, F after bit k equals pattern bit k. An abort in cycle c after start
  // leaves c-2 bits captured (none when aborted during the FSM reset cycle).
  function automatic exp_t model(input logic [7:0] p, input int ln, input int ac, input int s);
    exp_t r;
    int l;
    int n;
    logic [7:0] m;
    l = (ln == 0 || ln > 8) ? 8 : ln;
    n = (ac == 0) ? l : ((ac >= 2) ? ac - 2 : 0);
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    r.is_abort = (ac != 0);
    r.cyc      = 32'((ac == 0) ? s + l + 3 : s + ac + 1);
    r.trace    = p & m;
    r.count    = 4'($countones(r.trace));
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (!busy) check("dut_x_idle", 32'(dut_x), 32'd0);
      if (done || aborted) begin
        if (sb.size() == 0) begin
          check("unexpected_end_pulse", 32'({done, aborted}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("end_kind_done", 32'(done), 32'(!mon_e.is_abort));
          check("end_kind_aborted", 32'(aborted), 32'(mon_e.is_abort));
          check("end_cycle", 32'(cyc), mon_e.cyc);
          check("f_trace", 32'(f_trace), 32'(mon_e.trace));
          check("f_count", 32'(f_count), 32'(mon_e.count));
        end
      end
    end
  end

  // One run: ac = cycle (after start) in which abort is raised, 0 for none;
  // poke = also pulse start while busy and start/abort in the DONE cycle.
  task automatic do_run(input logic [7:0] p, input int ln, input int ac, input bit poke);
    exp_t e;
    int s;
    int l;
    int evk;
    @(negedge clk);
    pattern = p;
    len     = 4'(ln);
    start   = 1'b1;
    s       = cyc;
    e       = model(p, ln, ac, s);
    sb.push_back(e);
    l   = (ln == 0 || ln > 8) ? 8 : ln;
    evk = (ac > 0) ? ac + 1 : l + 3;
    for (int k = 1; k <= evk + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("dut_rst_pulse", 32'(dut_rst), 32'd1);
        pattern = 8'($urandom);
        len     = 4'($urandom);
      end
      if (k == 2) check("dut_rst_release", 32'(dut_rst), 32'd0);
      abort = (k == ac) || (poke && ac == 0 && k == l + 3);
      start = poke && ((ac != 1 && k == 2) || (ac == 0 && k == l + 3));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (l + 4) @(negedge clk);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_f_trace", 32'(f_trace), 32'(e.trace));
    check("hold_f_count", 32'(f_count), 32'(e.count));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_f_trace", 32'(f_trace), 32'd0);
    check("rst_f_count", 32'(f_count), 32'd0);
    check("rst_dut_x", 32'(dut_x), 32'd0);
    check("rst_dut_rst", 32'(dut_rst), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_dut_rst", 32'(dut_rst), 32'd0);

    do_run(8'hA5, 8, 0, 1'b0);
    do_run(8'hFF, 3, 0, 1'b0);
    do_run(8'hFF, 0, 0, 1'b0);
    do_run(8'h3C, 5, 0, 1'b1);
    do_run(8'hFF, 8, 5, 1'b0);
    do_run(8'h5A, 8, 0, 1'b0);
    do_run(8'hC3, 12, 1, 1'b1);
    do_run(8'h81, 2, 4, 1'b0);

    // Reset in the middle of a shift discards the run.
    @(negedge clk);
    pattern = 8'hFF;
    len     = 4'd8;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_f_trace", 32'(f_trace), 32'd0);
    check("midrst_f_count", 32'(f_count), 32'd0);
    check("midrst_dut_x", 32'(dut_x), 32'd0);
    check("midrst_dut_rst", 32'(dut_rst), 32'd1);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    do_run(8'h01, 1, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int ln;
      int l;
      int ac;
      ln = int'($urandom_range(0, 15));
      l  = (ln == 0 || ln > 8) ? 8 : ln;
      ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, l + 2)) : 0;
      do_run(8'($urandom), ln, ac, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
